// File: rtl/control_display_7seg.sv
// Scan controller for a bank of common-anode 7-segment digits.
// One nibble per slot is presented to the shared decoder. The slot's anode
// lights only after a dead-time blanking interval. New values wait in a
// pending register. They reach the displayed (shadow) register at a frame
// boundary, so a frame never mixes old and new digits.
module control_display_7seg #(
  parameter int N_DIGITOS = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 100
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Habilita,
  input  logic                   i_Load,
  input  logic [4*N_DIGITOS-1:0] i_Valor,
  input  logic [N_DIGITOS-1:0]   i_Puntos,
  input  logic                   i_SupCeros,
  output logic [3:0]             o_Deco,
  output logic                   o_Punto,
  output logic [N_DIGITOS-1:0]   o_Anodos,
  output logic                   o_Frame,
  output logic                   o_Pendiente
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITOS - 1);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;

  logic [4*N_DIGITOS-1:0] shadow_val_q, shadow_val_d;
  logic [N_DIGITOS-1:0]   shadow_pts_q, shadow_pts_d;
  logic                   shadow_sup_q, shadow_sup_d;
  logic [4*N_DIGITOS-1:0] pend_val_q, pend_val_d;
  logic [N_DIGITOS-1:0]   pend_pts_q, pend_pts_d;
  logic                   pend_sup_q, pend_sup_d;
  logic                   pflag_q, pflag_d;

  logic [3:0]             deco_q, deco_d;
  logic                   punto_q, punto_d;
  logic [N_DIGITOS-1:0]   anodos_q, anodos_d;
  logic                   frame_q, frame_d;

  logic                   frame_end;
  logic [N_DIGITOS-1:0]   supp;

  assign frame_end = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

  // Slot counter, digit index, scan FSM and pending/shadow bookkeeping.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    state_d      = state_q;
    shadow_val_d = shadow_val_q;
    shadow_pts_d = shadow_pts_q;
    shadow_sup_d = shadow_sup_q;
    pend_val_d   = pend_val_q;
    pend_pts_d   = pend_pts_q;
    pend_sup_d   = pend_sup_q;
    pflag_d      = pflag_q;
    frame_d      = 1'b0;

    if (!i_Habilita) begin
      // Disabled: park the scan and apply updates directly to shadow.
      cnt_d   = '0;
      idx_d   = '0;
      state_d = ST_BLANK;
      if (i_Load) begin
        shadow_val_d = i_Valor;
        shadow_pts_d = i_Puntos;
        shadow_sup_d = i_SupCeros;
      end else if (pflag_q) begin
        shadow_val_d = pend_val_q;
        shadow_pts_d = pend_pts_q;
        shadow_sup_d = pend_sup_q;
      end
      pflag_d = 1'b0;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end

      case (state_q)
        ST_BLANK: if (cnt_d == CNT_SHOW) state_d = ST_SHOW;
        ST_SHOW:  if (cnt_q == CNT_LAST) state_d = ST_BLANK;
        default:  state_d = ST_BLANK;
      endcase

      // A load in the frame-end cycle bypasses pending and lands in shadow.
      if (frame_end) begin
        frame_d = 1'b1;
        if (i_Load) begin
          shadow_val_d = i_Valor;
          shadow_pts_d = i_Puntos;
          shadow_sup_d = i_SupCeros;
        end else if (pflag_q) begin
          shadow_val_d = pend_val_q;
          shadow_pts_d = pend_pts_q;
          shadow_sup_d = pend_sup_q;
        end
        pflag_d = 1'b0;
      end else if (i_Load) begin
        pend_val_d = i_Valor;
        pend_pts_d = i_Puntos;
        pend_sup_d = i_SupCeros;
        pflag_d    = 1'b1;
      end
    end
  end

  // Leading-zero suppression mask, evaluated on the shadow value in effect next cycle.
  always_comb begin
    logic zero_above;
    supp       = '0;
    zero_above = 1'b1;
    for (int unsigned j = 0; j < N_DIGITOS - 1; j++) begin
      zero_above = zero_above && (shadow_val_d[4*(N_DIGITOS-1-j) +: 4] == 4'h0);
      supp[N_DIGITOS-1-j] = shadow_sup_d && zero_above;
    end
  end

  // Output values aligned with the next-cycle slot position.
  always_comb begin
    deco_d   = deco_q;
    punto_d  = punto_q;
    anodos_d = '1;
    if (cnt_d == '0) begin
      deco_d  = shadow_val_d[int'(idx_d)*4 +: 4];
      punto_d = ~shadow_pts_d[idx_d];
    end
    if (state_d == ST_SHOW && !supp[idx_d]) begin
      anodos_d[idx_d] = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_pts_q <= '0;
      shadow_sup_q <= 1'b0;
      pend_val_q   <= '0;
      pend_pts_q   <= '0;
      pend_sup_q   <= 1'b0;
      pflag_q      <= 1'b0;
      deco_q       <= '0;
      punto_q      <= 1'b1;
      anodos_q     <= '1;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_pts_q <= shadow_pts_d;
      shadow_sup_q <= shadow_sup_d;
      pend_val_q   <= pend_val_d;
      pend_pts_q   <= pend_pts_d;
      pend_sup_q   <= pend_sup_d;
      pflag_q      <= pflag_d;
      deco_q       <= deco_d;
      punto_q      <= punto_d;
      anodos_q     <= anodos_d;
      frame_q      <= frame_d;
    end
  end

  assign o_Deco      = deco_q;
  assign o_Punto     = punto_q;
  assign o_Anodos    = anodos_q;
  assign o_Frame     = frame_q;
  assign o_Pendiente = pflag_q;

endmodule

// File: doc/control_display_7seg.md
Name: control_display_7seg

Overview:
- Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
- Sequences the shared binary-to-7-segment decoder: presents one 4-bit nibble per slot on o_Deco, and enables the matching anode after a dead-time blanking interval.
- Values are loaded through a one-cycle load strobe into a pending register. They move to the displayed (shadow) register only at a frame boundary, so the display never tears.
- Sits between the application logic and the decoder/anode pins.

Parameters:
N_DIGITOS, 4, number of digits scanned; range 2..8.
PRESCALE, 50000, clock cycles per digit slot; must be > BLANK_CYC.
BLANK_CYC, 100, cycles at the start of each slot with all anodes off; must be >= 1.

Ports:
i_Clk  input  1  system clock; all logic is on the rising edge.
i_Reset  input  1  synchronous reset, active-high.
i_Habilita  input  1  scan enable; low forces the display dark.
i_Load  input  1  one-cycle strobe; captures i_Valor, i_Puntos, i_SupCeros into the pending register.
i_Valor  input  4*N_DIGITOS  packed nibbles; digit 0 = bits [3:0] (LSD).
i_Puntos  input  N_DIGITOS  decimal point per digit, 1 = lit.
i_SupCeros  input  1  1 = suppress leading zeros.
o_Deco  output  4  nibble for the decoder input.
o_Punto  output  1  decimal point for the current digit, active-low.
o_Anodos  output  N_DIGITOS  anode enables, active-low; all 1 = dark.
o_Frame  output  1  one-cycle pulse at the end of each full scan frame.
o_Pendiente  output  1  high while a loaded value waits for a frame boundary.

Behaviour:
- All outputs are registered.
- Reset values:
  - o_Anodos = all 1, o_Deco = 0, o_Punto = 1, o_Frame = 0, o_Pendiente = 0.
  - Shadow and pending registers = 0; digit index = 0; slot counter = 0; state = BLANK.
- Slot counter runs 0..PRESCALE-1 and wraps.
- FSM states:
  - BLANK: counter 0..BLANK_CYC-1. o_Anodos all 1. o_Deco and o_Punto are updated in cycle 0 of the slot from the shadow nibble of the current digit.
  - SHOW: counter BLANK_CYC..PRESCALE-1. The anode for the current digit is 0, unless that digit is suppressed.
  - Transitions: BLANK -> SHOW when the counter reaches BLANK_CYC. SHOW -> BLANK when the counter wraps, and the digit index increments modulo N_DIGITOS.
- Scan order is digit 0, 1, ..., N_DIGITOS-1, then back to 0.
- Frame end is the last cycle of the slot for digit N_DIGITOS-1.
  - On the next edge, o_Frame = 1 for exactly one cycle.
  - On the same edge, if o_Pendiente = 1, pending is copied to shadow and o_Pendiente clears.
- Load rules:
  - i_Load captures into pending and sets o_Pendiente on the next edge.
  - A second load before the frame boundary overwrites pending; the last one wins.
  - If i_Load coincides with the frame-end cycle, the new data goes straight to shadow and o_Pendiente stays 0.
- Leading-zero suppression (evaluated on shadow):
  - Digit k is suppressed if shadow SupCeros = 1, k > 0, and nibbles N_DIGITOS-1 down to k are all 0.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps its anode at 1 for the whole slot; timing is unchanged.
- o_Punto = ~Puntos[k] during the slot of digit k. Points on suppressed digits are not visible, because the anode is off.
- i_Habilita = 0 forces, on the next edge:
  - o_Anodos all 1, state BLANK, counter 0, index 0, o_Frame 0.
  - Pending is applied to shadow immediately.
- While i_Habilita = 0, further loads go directly to shadow. Scan restarts from digit 0 on the cycle after i_Habilita returns to 1.
- Reset mid-slot returns everything to the reset values on the next edge. No partial anode pulse is allowed.
- At most one anode bit is 0 in any cycle.

Test Plan:
(All with PRESCALE=8, BLANK_CYC=2, N_DIGITOS=4.)
1. Reset, then load 0x1234, SupCeros=0.
   - Required: o_Pendiente=1 until the first o_Frame.
   - Next frame: o_Deco is 4,3,2,1 on slots 0..3, and o_Anodos shows 1110,1101,1011,0111 for 6 cycles each, with 2 dark cycles before each.
2. Load 0x0070 with SupCeros=1.
   - Required: digits 0 and 1 light (nibbles 0, 7); digits 2 and 3 stay dark; o_Frame period stays 32 cycles.
3. Load 0x0000, SupCeros=1, Puntos=4'b0001.
   - Required: only digit 0 lights, showing 0 with o_Punto=0.
4. Two loads, 0xAAAA then 0x5555, inside one frame.
   - Required: the next frame shows 5,5,5,5 only; 0xAAAA never appears.
   - Then load exactly on the frame-end cycle: the new value shows in the very next slot 0, and o_Pendiente never rises.
5. Drop i_Habilita mid-SHOW of digit 2.
   - Required: o_Anodos=1111 on the next edge. While low, o_Frame never pulses and o_Anodos stays all 1.
   - After re-enable, the scan resumes at digit 0 with a 2-cycle blank.
6. Assert i_Reset during SHOW of digit 3.
   - Required: all outputs at reset values on the next edge; the shadow register reads 0 (scan after release shows 0000).
